// File: rtl/keypad_menu_ctrl.sv
// keypad_menu_ctrl
//   Converts the debounced 2-key keypad code into single-cycle key events,
//   SELECT long-press detection and (optionally) NEXT auto-repeat. It also
//   maintains the screen index and the menu lock flag.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   key_state  in   [1:0] key code: 00 none, 01 NEXT, 10 SELECT (11 -> none)
//   next_p     out  1-cycle pulse, NEXT accepted (press or auto-repeat)
//   sel_p      out  1-cycle pulse, SELECT released before long press
//   long_p     out  1-cycle pulse, SELECT long press reached
//   mode       out  [$clog2(NUM_MODES)-1:0] current screen index
//   locked     out  menu lock; NEXT ignored while set
//
// Configuration
//   KEYPAD_MENU_REPEAT_EN  when defined, a NEXT held past the long-press time
//                          repeats every REPEAT_CYCLES cycles.
module keypad_menu_ctrl #(
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 12_500_000,
  parameter int NUM_MODES         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   key_state,
  output logic                         next_p,
  output logic                         sel_p,
  output logic                         long_p,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic                         locked
);

  localparam int MAXC = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam int MW   = $clog2(NUM_MODES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
`ifdef KEYPAD_MENU_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif
  localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

  state_t          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic            armed_q, armed_d;
  logic            sel_key_q, sel_key_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            next_q, next_d;
  logic            sel_q, sel_d;
  logic            long_q, long_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic            locked_q, locked_d;
  logic [1:0]      held_code;

  function automatic logic [MW-1:0] mode_inc(input logic [MW-1:0] m);
    return (m == MODE_LAST) ? '0 : m + 1'b1;
  endfunction

  // Counter saturates at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign k_d       = (key_state == 2'b11) ? 2'b00 : key_state;
  assign held_code = sel_key_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d   = state_q;
    sel_key_d = sel_key_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    locked_d  = locked_q;
    next_d    = 1'b0;
    sel_d     = 1'b0;
    long_d    = 1'b0;
    // A key held through reset stays ignored until a released cycle is seen.
    armed_d   = armed_q | (k_q == 2'b00);
    unique case (state_q)
      IDLE: begin
        if (armed_q && (k_q != 2'b00)) begin
          state_d   = PRESS;
          sel_key_d = k_q[1];
          cnt_d     = '0;
          if (!k_q[1] && !locked_q) begin
            next_d = 1'b1;
            mode_d = mode_inc(mode_q);
          end
        end
      end
      PRESS: begin
        if (k_q != held_code) begin
          // Release or direct change to the other key; the new key, if any,
          // is taken as a fresh press from IDLE on the next cycle.
          state_d = IDLE;
          sel_d   = sel_key_q;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (sel_key_q) begin
            long_d   = 1'b1;
            locked_d = !locked_q;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      HOLD: begin
        if (k_q != held_code) begin
          state_d = IDLE;
        end else begin
`ifdef KEYPAD_MENU_REPEAT_EN
          if (!sel_key_q && !locked_q && (cnt_q == REP_LAST)) begin
            next_d = 1'b1;
            mode_d = mode_inc(mode_q);
            cnt_d  = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
`else
          cnt_d = sat_inc(cnt_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Input register is not reset so a key held through reset is still visible
  // (and therefore not mistaken for a released cycle) right after reset.
  always_ff @(posedge clk) begin
    k_q <= k_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      sel_key_q <= 1'b0;
      cnt_q     <= '0;
      next_q    <= 1'b0;
      sel_q     <= 1'b0;
      long_q    <= 1'b0;
      mode_q    <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      sel_key_q <= sel_key_d;
      cnt_q     <= cnt_d;
      next_q    <= next_d;
      sel_q     <= sel_d;
      long_q    <= long_d;
      mode_q    <= mode_d;
      locked_q  <= locked_d;
    end
  end

  assign next_p = next_q;
  assign sel_p  = sel_q;
  assign long_p = long_q;
  assign mode   = mode_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_keypad_menu_ctrl.sv
// Testbench for keypad_menu_ctrl: a cycle table, hand-written corner-case
// sequences and randomized key runs checked against a duration-based model.
module tb_keypad_menu_ctrl;

  localparam int LONG = 8;
  localparam int REP  = 4;
  localparam int NM   = 3;
`ifdef KEYPAD_MENU_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_state = 2'b00;
  logic       next_p, sel_p, long_p, locked;
  logic [1:0] mode;

  keypad_menu_ctrl #(
    .LONG_PRESS_CYCLES(LONG),
    .REPEAT_CYCLES    (REP),
    .NUM_MODES        (NM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_state(key_state),
    .next_p   (next_p),
    .sel_p    (sel_p),
    .long_p   (long_p),
    .mode     (mode),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many cycles the recognised key has been seen.
  bit         m_active = 0, m_armed = 0, m_sel_key = 0, m_locked = 0;
  int         m_held = 0, m_mode = 0;
  bit         e_next = 0, e_sel = 0, e_long = 0;
  logic [1:0] m_k = 2'b00;
  bit         mdl_en = 0;

  always @(posedge clk) begin
    logic [1:0] k;
    k = m_k;
    e_next = 0; e_sel = 0; e_long = 0;
    if (rst) begin
      m_active = 0; m_armed = 0; m_mode = 0; m_locked = 0; m_held = 0;
    end else begin
      if (!m_active) begin
        if (m_armed && k != 2'd0) begin
          m_active  = 1;
          m_sel_key = (k == 2'd2);
          m_held    = 1;
          if (!m_sel_key && !m_locked) begin
            e_next = 1;
            m_mode = (m_mode + 1) % NM;
          end
        end
      end else if (k != (m_sel_key ? 2'd2 : 2'd1)) begin
        m_active = 0;
        if (m_sel_key && m_held <= LONG) e_sel = 1;
      end else begin
        m_held++;
        if (m_sel_key && m_held == LONG + 1) begin
          e_long   = 1;
          m_locked = !m_locked;
        end
        if (REP_EN && !m_sel_key && !m_locked && m_held > LONG + 1 &&
            ((m_held - (LONG + 1)) % REP) == 0) begin
          e_next = 1;
          m_mode = (m_mode + 1) % NM;
        end
      end
      if (k == 2'd0) m_armed = 1;
    end
    m_k = (key_state == 2'b11) ? 2'b00 : key_state;
  end

  always @(negedge clk) begin
    if (mdl_en)
      chk("model", int'({next_p, sel_p, long_p, mode, locked}),
          int'({e_next, e_sel, e_long, m_mode[1:0], m_locked}));
  end

  int n_next, n_sel, n_long;

  task automatic clr_cnt();
    n_next = 0; n_sel = 0; n_long = 0;
  endtask

  // Apply inputs for n cycles; called at a negedge, returns at a negedge.
  task automatic cyc(input logic r, input logic [1:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r;
      key_state = k;
      @(posedge clk);
      @(negedge clk);
      n_next += int'(next_p);
      n_sel  += int'(sel_p);
      n_long += int'(long_p);
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 2'b00, 2);
    cyc(1'b0, 2'b00, 1);
    clr_cnt();
  endtask

  typedef struct {
    logic       r;
    logic [1:0] k;
    logic       nx, sl, lg;
    logic [1:0] md;
    logic       lk;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};

    clr_cnt();
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].r, tbl[i].k, 1);
      if (i == 0) mdl_en = 1;
      chk($sformatf("tbl%0d", i), int'({next_p, sel_p, long_p, mode, locked}),
          int'({tbl[i].nx, tbl[i].sl, tbl[i].lg, tbl[i].md, tbl[i].lk}));
    end

    // NEXT tap then three more taps: mode 1 -> 2 -> 0 -> 1
    do_reset();
    cyc(1'b0, 2'b01, 3); cyc(1'b0, 2'b00, 3);
    chk("tap_next_cnt", n_next, 1);
    chk("tap_mode", int'(mode), 1);
    chk("tap_no_sel_long", n_sel + n_long, 0);
    clr_cnt();
    for (int t = 0; t < 3; t++) begin
      cyc(1'b0, 2'b01, 2); cyc(1'b0, 2'b00, 2);
    end
    chk("wrap_next_cnt", n_next, 3);
    chk("wrap_mode", int'(mode), 1);

    // Short SELECT
    clr_cnt();
    cyc(1'b0, 2'b10, 4); cyc(1'b0, 2'b00, 3);
    chk("short_sel_cnt", n_sel, 1);
    chk("short_sel_locked", int'(locked), 0);
    chk("short_sel_mode", int'(mode), 1);

    // Long SELECT locks, NEXT ignored, second long SELECT unlocks
    clr_cnt();
    cyc(1'b0, 2'b10, 20); cyc(1'b0, 2'b00, 3);
    chk("long_cnt", n_long, 1);
    chk("long_no_sel", n_sel, 0);
    chk("long_locked", int'(locked), 1);
    clr_cnt();
    cyc(1'b0, 2'b01, 2); cyc(1'b0, 2'b00, 2);
    chk("locked_next_cnt", n_next, 0);
    chk("locked_mode", int'(mode), 1);
    clr_cnt();
    cyc(1'b0, 2'b10, 20); cyc(1'b0, 2'b00, 3);
    chk("unlock_long_cnt", n_long, 1);
    chk("unlock_locked", int'(locked), 0);

    // NEXT held 20 cycles from mode 0
    do_reset();
    cyc(1'b0, 2'b01, 20); cyc(1'b0, 2'b00, 3);
    chk("hold_next_cnt", n_next, REP_EN ? 3 : 1);
    chk("hold_mode", int'(mode), REP_EN ? 0 : 1);

    // NEXT held across a reset pulse
    do_reset();
    cyc(1'b0, 2'b01, 3);
    cyc(1'b1, 2'b01, 1);
    clr_cnt();
    cyc(1'b0, 2'b01, 10);
    chk("rst_hold_pulses", n_next + n_sel + n_long, 0);
    chk("rst_hold_mode", int'(mode), 0);
    cyc(1'b0, 2'b00, 2);
    clr_cnt();
    cyc(1'b0, 2'b01, 3); cyc(1'b0, 2'b00, 3);
    chk("rst_rearm_next", n_next, 1);

    // Direct NEXT -> SELECT change
    clr_cnt();
    cyc(1'b0, 2'b01, 3); cyc(1'b0, 2'b10, 3); cyc(1'b0, 2'b00, 3);
    chk("direct_next", n_next, 1);
    chk("direct_sel", n_sel, 1);

    // Randomized key runs with occasional reset
    for (int r = 0; r < 300; r++) begin
      logic [1:0] k;
      k = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) cyc(1'b1, k, 1);
      cyc(1'b0, k, $urandom_range(1, 16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
